// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : move_sequencer
// Purpose  : Grid movement sequencer. Accepts a move request, reads the
//            target map row, checks the wall bit and commits or rejects the
//            new tile. Owns the player position and the current map id, and
//            rate-limits moves with a fixed cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module move_sequencer #(
  parameter int MAP_W    = 20,
  parameter int MAP_H    = 15,
  parameter int START_X  = 1,
  parameter int START_Y  = 1,
  parameter int COOLDOWN = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             move_req_i,
  input  logic [2:0]       move_dir_i,
  input  logic [1:0]       map_sel_i,
  output logic [1:0]       map_id_o,
  output logic             map_rd_en_o,
  output logic [3:0]       map_row_addr_o,
  input  logic [MAP_W-1:0] map_row_data_i,
  output logic [4:0]       pos_x_o,
  output logic [4:0]       pos_y_o,
  output logic             busy_o,
  output logic             move_done_o,
  output logic             blocked_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  localparam logic [4:0]  c_start_x  = 5'(START_X);
  localparam logic [4:0]  c_start_y  = 5'(START_Y);
  localparam logic [5:0]  c_map_w    = 6'(MAP_W);
  localparam logic [5:0]  c_map_h    = 6'(MAP_H);
  localparam logic [15:0] c_cooldown = 16'(COOLDOWN);
  // With no cooldown the attempt returns straight to IDLE.
  localparam state_t      c_after    = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;

  state_t      state_q, state_d;
  logic [1:0]  map_id_q, map_id_d;
  logic [4:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [4:0]  tx_q, tx_d, ty_q, ty_d;
  logic        rd_en_q, rd_en_d;
  logic [3:0]  row_addr_q, row_addr_d;
  logic        done_q, done_d;
  logic        blocked_q, blocked_d;
  logic [15:0] cnt_q, cnt_d;

  logic [4:0]  w_tx, w_ty;
  logic        w_dir_ok, w_oob, w_wall;

  // Candidate target tile from the current position; 5-bit wrap makes x-1 at 0 land out of bounds.
  always_comb begin
    w_tx     = pos_x_q;
    w_ty     = pos_y_q;
    w_dir_ok = 1'b1;
    case (move_dir_i)
      3'b100:  w_tx = pos_x_q + 5'd1;
      3'b001:  w_ty = pos_y_q - 5'd1;
      3'b010:  w_tx = pos_x_q - 5'd1;
      3'b011:  w_ty = pos_y_q + 5'd1;
      default: w_dir_ok = 1'b0;
    endcase
    w_oob = ({1'b0, w_tx} >= c_map_w) || ({1'b0, w_ty} >= c_map_h);
  end

  // Wall bit of the latched target column within the returned row word.
  always_comb begin
    w_wall = 1'b0;
    for (int i = 0; i < MAP_W; i++) begin
      if (tx_q == 5'(i)) w_wall = map_row_data_i[i];
    end
  end

  // Next-state and registered-output logic; pulses and read strobe default low.
  always_comb begin
    state_d    = state_q;
    map_id_d   = map_id_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    rd_en_d    = 1'b0;
    row_addr_d = row_addr_q;
    done_d     = 1'b0;
    blocked_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (map_sel_i != map_id_q) begin
          map_id_d = map_sel_i;
          pos_x_d  = c_start_x;
          pos_y_d  = c_start_y;
        end else if (move_req_i && w_dir_ok) begin
          if (w_oob) begin
            blocked_d = 1'b1;
            state_d   = c_after;
            cnt_d     = c_cooldown;
          end else begin
            tx_d       = w_tx;
            ty_d       = w_ty;
            rd_en_d    = 1'b1;
            row_addr_d = w_ty[3:0];
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (w_wall) begin
          blocked_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          pos_x_d = tx_q;
          pos_y_d = ty_q;
        end
        state_d = c_after;
        cnt_d   = c_cooldown;
      end
      ST_COOL: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      map_id_q   <= 2'd0;
      pos_x_q    <= c_start_x;
      pos_y_q    <= c_start_y;
      tx_q       <= 5'd0;
      ty_q       <= 5'd0;
      rd_en_q    <= 1'b0;
      row_addr_q <= 4'd0;
      done_q     <= 1'b0;
      blocked_q  <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      map_id_q   <= map_id_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      rd_en_q    <= rd_en_d;
      row_addr_q <= row_addr_d;
      done_q     <= done_d;
      blocked_q  <= blocked_d;
      cnt_q      <= cnt_d;
    end
  end

  assign map_id_o       = map_id_q;
  assign map_rd_en_o    = rd_en_q;
  assign map_row_addr_o = row_addr_q;
  assign pos_x_o        = pos_x_q;
  assign pos_y_o        = pos_y_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign move_done_o    = done_q;
  assign blocked_o      = blocked_q;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_sequencer
// Purpose  : Self-checking bench for move_sequencer: directed scenarios with
//            fixed expectations plus a random run against a schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;
  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int SX    = 1;
  localparam int SY    = 1;
  localparam int CD    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic [2:0]       dir = 3'd0;
  logic [1:0]       sel = 2'd0;
  logic [MAP_W-1:0] row_data = '0;
  logic [1:0]       map_id;
  logic             rd_en;
  logic [3:0]       row_addr;
  logic [4:0]       pos_x, pos_y;
  logic             busy, done, blk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [MAP_W-1:0] mem [4][16];

  move_sequencer #(.MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(SX), .START_Y(SY), .COOLDOWN(CD)) dut (
    .clk_i(clk), .reset_i(rst), .move_req_i(req), .move_dir_i(dir), .map_sel_i(sel),
    .map_id_o(map_id), .map_rd_en_o(rd_en), .map_row_addr_o(row_addr), .map_row_data_i(row_data),
    .pos_x_o(pos_x), .pos_y_o(pos_y), .busy_o(busy), .move_done_o(done), .blocked_o(blk)
  );

  always #5 clk = ~clk;

  // Map memory: row valid the cycle after the strobe, junk at all other times.
  always @(posedge clk) begin
    if (rd_en) row_data <= mem[map_id][row_addr];
    else       row_data <= MAP_W'($urandom);
  end

  // Reference model: each accepted move is a schedule of busy cycles with the
  // read one cycle out and the result two edges after the accept.
  int         m_left = 0, m_pend = 0;
  logic [4:0] m_x, m_y, m_tx, m_ty;
  logic [1:0] m_map;
  logic [3:0] m_addr;
  logic       m_done, m_blk, m_rd, m_wall, m_ok;

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0; m_blk = 1'b0; m_rd = 1'b0;
    if (rst) begin
      m_left = 0; m_pend = 0; m_x = 5'(SX); m_y = 5'(SY); m_map = 2'd0; m_addr = 4'd0;
    end else if (m_left == 0) begin
      if (sel != m_map) begin
        m_map = sel; m_x = 5'(SX); m_y = 5'(SY);
      end else if (req) begin
        m_tx = m_x; m_ty = m_y; m_ok = 1'b1;
        case (dir)
          3'b100:  m_tx = m_x + 5'd1;
          3'b001:  m_ty = m_y - 5'd1;
          3'b010:  m_tx = m_x - 5'd1;
          3'b011:  m_ty = m_y + 5'd1;
          default: m_ok = 1'b0;
        endcase
        if (m_ok) begin
          if (int'(m_tx) >= MAP_W || int'(m_ty) >= MAP_H) begin
            m_blk = 1'b1; m_left = CD;
          end else begin
            m_rd = 1'b1; m_addr = m_ty[3:0];
            m_wall = mem[m_map][m_ty][m_tx];
            m_pend = 2; m_left = CD + 2;
          end
        end
      end
    end else begin
      m_left--;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          if (m_wall) m_blk = 1'b1;
          else begin m_done = 1'b1; m_x = m_tx; m_y = m_ty; end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // One request cycle, then enough cycles to be back in IDLE.
  task automatic move_once(input logic [2:0] d);
    req = 1'b1; dir = d;
    tick();
    req = 1'b0;
    repeat (CD + 3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; sel = 2'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (pos_x !== 5'd1 || pos_y !== 5'd1 || map_id !== 2'd0 || busy !== 1'b0 || done !== 1'b0 ||
        blk !== 1'b0 || rd_en !== 1'b0 || row_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got pos=(%0d,%0d) map=%0d busy=%b done=%b blk=%b rd=%b addr=%0d exp pos=(1,1) all zero",
               pos_x, pos_y, map_id, busy, done, blk, rd_en, row_addr);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (pos_x !== 5'd1 || pos_y !== 5'd1 || busy !== 1'b0 || done !== 1'b0 || blk !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold k=%0d got pos=(%0d,%0d) busy=%b done=%b blk=%b exp (1,1) 0 0 0",
                 k, pos_x, pos_y, busy, done, blk);
      end
    end
  endtask

  task automatic test_move_right();
    mem[0][1] = 20'b10000000000000000001;
    req = 1'b1; dir = 3'b100;
    tick();
    req = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || row_addr !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL right_read got rd=%b addr=%0d busy=%b exp 1 1 1", rd_en, row_addr, busy);
    end
    tick();
    checks++;
    if (rd_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL right_wait got rd=%b done=%b exp 0 0", rd_en, done);
    end
    tick();
    checks++;
    if (pos_x !== 5'd2 || pos_y !== 5'd1 || done !== 1'b1 || blk !== 1'b0) begin
      errors++;
      $display("FAIL right_commit got pos=(%0d,%0d) done=%b blk=%b exp (2,1) 1 0", pos_x, pos_y, done, blk);
    end
    for (int k = 4; k <= 11; k++) begin
      tick();
      checks++;
      if (busy !== (k != 11) || done !== 1'b0) begin
        errors++;
        $display("FAIL right_cool N+%0d got busy=%b done=%b exp busy=%b done=0", k, busy, done, k != 11);
      end
    end
  endtask

  task automatic test_wall_up();
    move_once(3'b010);
    mem[0][0] = '1;
    req = 1'b1; dir = 3'b001;
    tick();
    req = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || row_addr !== 4'd0) begin
      errors++;
      $display("FAIL up_read got rd=%b addr=%0d exp 1 0", rd_en, row_addr);
    end
    tick(); tick();
    checks++;
    if (blk !== 1'b1 || done !== 1'b0 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
      errors++;
      $display("FAIL up_wall got blk=%b done=%b pos=(%0d,%0d) exp 1 0 (1,1)", blk, done, pos_x, pos_y);
    end
    repeat (CD + 1) tick();
  endtask

  task automatic test_bounds();
    mem[0][1] = '0;
    move_once(3'b010);
    checks++;
    if (pos_x !== 5'd0 || pos_y !== 5'd1) begin
      errors++;
      $display("FAIL edge_pos got (%0d,%0d) exp (0,1)", pos_x, pos_y);
    end
    req = 1'b1; dir = 3'b010;
    tick();
    req = 1'b0;
    checks++;
    if (blk !== 1'b1 || rd_en !== 1'b0 || done !== 1'b0 || pos_x !== 5'd0 || pos_y !== 5'd1) begin
      errors++;
      $display("FAIL left_oob got blk=%b rd=%b done=%b pos=(%0d,%0d) exp 1 0 0 (0,1)", blk, rd_en, done, pos_x, pos_y);
    end
    for (int k = 2; k <= CD + 1; k++) begin
      tick();
      checks++;
      if (busy !== (k != CD + 1) || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL oob_cool N+%0d got busy=%b rd=%b exp busy=%b rd=0", k, busy, rd_en, k != CD + 1);
      end
    end
    for (int k = 0; k < 13; k++) move_once(3'b011);
    checks++;
    if (pos_x !== 5'd0 || pos_y !== 5'd14) begin
      errors++;
      $display("FAIL down_walk got (%0d,%0d) exp (0,14)", pos_x, pos_y);
    end
    req = 1'b1; dir = 3'b011;
    tick();
    req = 1'b0;
    checks++;
    if (blk !== 1'b1 || rd_en !== 1'b0 || pos_y !== 5'd14) begin
      errors++;
      $display("FAIL down_oob got blk=%b rd=%b y=%0d exp 1 0 14", blk, rd_en, pos_y);
    end
    repeat (CD + 1) tick();
  endtask

  task automatic test_back_to_back();
    int n = 0, last = 0;
    req = 1'b1; dir = 3'b100;
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (done === 1'b1) begin
        if (n > 0) begin
          checks++;
          if (k - last != 11) begin
            errors++;
            $display("FAIL b2b_period got %0d exp 11", k - last);
          end
        end
        n++; last = k;
      end
      if (k == 44) req = 1'b0;
    end
    checks++;
    if (n != 4 || pos_x !== 5'd4 || pos_y !== 5'd14) begin
      errors++;
      $display("FAIL b2b_count got pulses=%0d pos=(%0d,%0d) exp 4 (4,14)", n, pos_x, pos_y);
    end
    repeat (CD + 3) tick();
    req = 1'b1; dir = 3'b111;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || blk !== 1'b0 || pos_x !== 5'd4) begin
        errors++;
        $display("FAIL bad_dir k=%0d got busy=%b rd=%b blk=%b x=%0d exp 0 0 0 4", k, busy, rd_en, blk, pos_x);
      end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_map_change();
    req = 1'b1; dir = 3'b100;
    tick();
    req = 1'b0;
    tick();
    sel = 2'd2;
    tick();
    checks++;
    if (done !== 1'b1 || pos_x !== 5'd5 || pos_y !== 5'd14 || map_id !== 2'd0) begin
      errors++;
      $display("FAIL mapchg_commit got done=%b pos=(%0d,%0d) map=%0d exp 1 (5,14) 0", done, pos_x, pos_y, map_id);
    end
    repeat (CD) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mapchg_idle got busy=%b exp 0", busy);
    end
    tick();
    checks++;
    if (map_id !== 2'd2 || pos_x !== 5'd1 || pos_y !== 5'd1) begin
      errors++;
      $display("FAIL mapchg_apply got map=%0d pos=(%0d,%0d) exp 2 (1,1)", map_id, pos_x, pos_y);
    end
  endtask

  task automatic test_reset_abort();
    move_once(3'b100);
    req = 1'b1; dir = 3'b100;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || blk !== 1'b0 || pos_x !== 5'd1 || pos_y !== 5'd1 || map_id !== 2'd0 ||
        busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort got done=%b blk=%b pos=(%0d,%0d) map=%0d busy=%b rd=%b exp 0 0 (1,1) 0 0 0",
               done, blk, pos_x, pos_y, map_id, busy, rd_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || map_id !== 2'd2 || pos_x !== 5'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_sel got done=%b map=%0d x=%0d busy=%b exp 0 2 1 0", done, map_id, pos_x, busy);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < 16; r++) mem[m][r] = MAP_W'($urandom & $urandom);
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 3) != 0);
      dir = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom);
      tick();
      checks++;
      if (pos_x !== m_x || pos_y !== m_y || map_id !== m_map) begin
        errors++;
        $display("FAIL rnd_state cyc=%0d got pos=(%0d,%0d) map=%0d exp pos=(%0d,%0d) map=%0d",
                 cyc, pos_x, pos_y, map_id, m_x, m_y, m_map);
      end
      checks++;
      if (busy !== (m_left != 0) || done !== m_done || blk !== m_blk) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got busy=%b done=%b blk=%b exp busy=%b done=%b blk=%b",
                 cyc, busy, done, blk, m_left != 0, m_done, m_blk);
      end
      checks++;
      if (rd_en !== m_rd || row_addr !== m_addr) begin
        errors++;
        $display("FAIL rnd_read cyc=%0d got rd=%b addr=%0d exp rd=%b addr=%0d", cyc, rd_en, row_addr, m_rd, m_addr);
      end
    end
    rst = 1'b0; req = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < 16; r++) mem[m][r] = '0;
    test_reset();
    test_move_right();
    test_wall_up();
    test_bounds();
    test_back_to_back();
    test_map_change();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
